// File: rtl/receive_send_if.sv
// Bit-line bus between the sender, the receive stage and consumers of the packed word.
// The sender drives one line per bit. The receive stage returns the word plus its status flags.
interface receive_send_if #(
    parameter int WORD_SIZE = 3
);
    logic                 data_in [WORD_SIZE:0];
    logic [WORD_SIZE:0]   data_out;
    logic                 data_valid;
    logic                 data_changed;
    logic                 parity;

    modport master (
        output data_in,
        input  data_out,
        input  data_valid,
        input  data_changed,
        input  parity
    );

    modport slave (
        input  data_in,
        output data_out,
        output data_valid,
        output data_changed,
        output parity
    );
endinterface

// File: rtl/receive_send.sv
// Receive stage: packs the per-bit lines into a registered word and reports valid, change and parity.
// Defining RECEIVE_SEND_PARITY_EN builds a registered even-parity output; otherwise parity is tied 0.
module receive_send #(
    parameter int WORD_SIZE = 3
) (
    input  logic          clk,
    input  logic          rst,
    receive_send_if.slave bus
);
    logic [WORD_SIZE:0] word_d;
    logic [WORD_SIZE:0] data_q;
    logic               valid_q;
    logic               changed_q;

    always_comb begin
        word_d = '0;
        for (int i = 0; i <= WORD_SIZE; i++) begin
            word_d[i] = bus.data_in[i];
        end
    end

    // Compare against the held word, so the first capture after reset is compared against 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            data_q    <= word_d;
            valid_q   <= 1'b1;
            changed_q <= (word_d != data_q);
        end
    end

`ifdef RECEIVE_SEND_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^word_d;
        end
    end

    assign bus.parity = parity_q;
`else
    assign bus.parity = 1'b0;
`endif

    assign bus.data_out     = data_q;
    assign bus.data_valid   = valid_q;
    assign bus.data_changed = changed_q;
endmodule

// File: tb/tb_receive_send.sv
// Directed bench for receive_send: reset, capture, hold, bit mapping, mid-stream reset, soak.
// Parity expectations follow RECEIVE_SEND_PARITY_EN as compiled.
module tb_receive_send;
    localparam int WS = 3;
`ifdef RECEIVE_SEND_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    receive_send_if #(.WORD_SIZE(WS)) bus ();

    receive_send #(.WORD_SIZE(WS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [WS:0] w);
        for (int i = 0; i <= WS; i++) begin
            bus.data_in[i] = w[i];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string nm, input logic [WS:0] e_out,
                           input logic e_val, input logic e_chg, input logic e_par);
        checks++;
        if (bus.data_out !== e_out) begin
            errors++;
            $display("FAIL %s data_out got=%b exp=%b", nm, bus.data_out, e_out);
        end
        checks++;
        if (bus.data_valid !== e_val) begin
            errors++;
            $display("FAIL %s data_valid got=%b exp=%b", nm, bus.data_valid, e_val);
        end
        checks++;
        if (bus.data_changed !== e_chg) begin
            errors++;
            $display("FAIL %s data_changed got=%b exp=%b", nm, bus.data_changed, e_chg);
        end
        checks++;
        if (bus.parity !== e_par) begin
            errors++;
            $display("FAIL %s parity got=%b exp=%b", nm, bus.parity, e_par);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(4'b1111);
        step();
        step();
        chk_all("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_single_capture();
        rst = 1'b0;
        drive(4'b1011);
        step();
        chk_all("single", 4'b1011, 1'b1, 1'b1, PAR_EN ? 1'b1 : 1'b0);
    endtask

    task automatic test_hold();
        for (int k = 0; k < 3; k++) begin
            step();
            chk_all("hold", 4'b1011, 1'b1, 1'b0, PAR_EN ? 1'b1 : 1'b0);
        end
    endtask

    task automatic test_bit_mapping();
        logic [WS:0] oh;
        for (int k = 0; k <= WS; k++) begin
            oh = '0;
            oh[k] = 1'b1;
            drive(oh);
            step();
            chk_all("onehot", oh, 1'b1, 1'b1, PAR_EN ? 1'b1 : 1'b0);
        end
    endtask

    task automatic test_mid_reset();
        drive(4'b0110);
        step();
        chk_all("pre_rst", 4'b0110, 1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        drive(4'b1001);
        step();
        chk_all("mid_rst", 4'b0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        chk_all("post_rst", 4'b1001, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_stable_between_edges();
        drive(4'b0101);
        #2;
        checks++;
        if (bus.data_out !== 4'b1001) begin
            errors++;
            $display("FAIL between_edges data_out got=%b exp=%b", bus.data_out, 4'b1001);
        end
        step();
        chk_all("after_edge", 4'b0101, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_soak();
        logic [WS:0] prev;
        logic [WS:0] w;
        prev = 4'b0101;
        for (int k = 0; k < 20; k++) begin
            w = 4'($urandom_range(0, 15));
            drive(w);
            step();
            chk_all("soak", w, 1'b1, (w != prev), PAR_EN ? ^w : 1'b0);
            prev = w;
        end
    endtask

    initial begin
        drive(4'b0000);
        test_reset();
        test_single_capture();
        test_hold();
        test_bit_mapping();
        test_mid_reset();
        test_stable_between_edges();
        test_soak();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
